// File: rtl/pipe_bram_ctrl.sv
// pipe_bram_ctrl
// Run-time sequencer for a BRAM-backed fixed-delay stream line. Drives the
// write/read ports of an external simple-dual-port BRAM (1-cycle read
// latency) so one physical buffer gives any delay D in 2..DEPTH, and tracks
// sample validity with a private tag array so only current-run samples
// emerge on vout.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   start, cfg_delay   begin a run with delay D (honoured in IDLE only)
//   flush              end the run and drain in-flight samples
//   vin                input sample valid this cycle
//   bram_we/bram_waddr BRAM write port control
//   bram_re/bram_raddr BRAM read port control
//   vout               valid aligned with BRAM read data
//   busy, warmed, done status: not idle, in RUN, last DRAIN cycle
//   err_cfg            sticky illegal-delay flag, cleared by a legal start
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no run; ports quiet, write address parked at 0
// FILL  | first D cycles of a run; buffer warming, warmed low
// RUN   | steady state, D-cycle delay line, until flush
// DRAIN | D cycles with writes off so in-flight samples emerge

module pipe_bram_ctrl #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W:0]   cfg_delay,
    input  logic              flush,
    input  logic              vin,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_waddr,
    output logic              bram_re,
    output logic [ADDR_W-1:0] bram_raddr,
    output logic              vout,
    output logic              busy,
    output logic              warmed,
    output logic              done,
    output logic              err_cfg
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] MIN_D   = (ADDR_W+1)'(2);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W-1:0]   wr_inc;
    logic [ADDR_W:0]     d_reg;
    logic [ADDR_W:0]     d_last;
    logic [ADDR_W:0]     act_cnt;
    logic [ADDR_W:0]     drain_cnt;
    logic [DEPTH-1:0]    tag;
    logic                active;
    logic                gate;
    logic                cfg_ok;
    logic                vout_r;
    logic                err_r;

    assign active = (state != IDLE);
    assign d_last = d_reg - 1'b1;
    assign cfg_ok = (cfg_delay >= MIN_D) && (cfg_delay <= DEPTH_V);
    // Next write address, which is also the read address: the slot written
    // D-1 cycles ago, whose BRAM data appears one cycle later, D after write.
    assign wr_inc = ({1'b0, wr_addr} == d_last) ? '0 : wr_addr + 1'b1;
    // act_cnt saturates at D-1; until then the addressed slots have not been
    // written in this run, so their tags are stale and must be masked.
    assign gate   = (act_cnt == d_last);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        bram_we    = 1'b0;
        bram_re    = 1'b0;
        bram_raddr = '0;
        case (state)
            IDLE: begin
                if (start && cfg_ok) state_nxt = FILL;
            end
            FILL: begin
                bram_we = vin;
                if (flush)                  state_nxt = DRAIN;
                else if (act_cnt == d_last) state_nxt = RUN;
            end
            RUN: begin
                bram_we = vin;
                if (flush) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (active) begin
            bram_re    = 1'b1;
            bram_raddr = wr_inc;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_addr   <= '0;
            d_reg     <= MIN_D;
            act_cnt   <= '0;
            drain_cnt <= '0;
            tag       <= '0;
            vout_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            if (state == IDLE) begin
                wr_addr <= '0;
                act_cnt <= '0;
                if (start) begin
                    if (cfg_ok) begin
                        d_reg <= cfg_delay;
                        err_r <= 1'b0;
                    end else begin
                        err_r <= 1'b1;
                    end
                end
            end else begin
                wr_addr      <= (state_nxt == IDLE) ? '0 : wr_inc;
                tag[wr_addr] <= vin & (state != DRAIN);
                if (!gate) act_cnt <= act_cnt + 1'b1;
            end

            if (state != DRAIN && state_nxt == DRAIN) begin
                drain_cnt <= d_last;
            end else if (state == DRAIN) begin
                drain_cnt <= drain_cnt - 1'b1;
            end

            vout_r <= active & gate & tag[wr_inc];
        end
    end

    assign bram_waddr = wr_addr;
    assign vout       = vout_r;
    assign busy       = active;
    assign warmed     = (state == RUN);
    assign done       = (state == DRAIN) && (drain_cnt == '0);
    assign err_cfg    = err_r;

endmodule

// File: tb/tb_pipe_bram_ctrl.sv
// Testbench for pipe_bram_ctrl. Reference model tracks each run as a
// timeline (cycle index k from the first FILL cycle, flush index f, vin
// history) and derives every output from that.

module tb_pipe_bram_ctrl;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   cfg_delay = '0;
    logic              flush = 1'b0;
    logic              vin = 1'b0;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_waddr;
    logic              bram_re;
    logic [ADDR_W-1:0] bram_raddr;
    logic              vout;
    logic              busy;
    logic              warmed;
    logic              done;
    logic              err_cfg;

    int errors = 0;
    int checks = 0;

    bit m_busy = 0;
    bit m_err  = 0;
    int m_k    = 0;
    int m_d    = 2;
    int m_f    = -1;
    bit hist [64];

    pipe_bram_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .cfg_delay  (cfg_delay),
        .flush      (flush),
        .vin        (vin),
        .bram_we    (bram_we),
        .bram_waddr (bram_waddr),
        .bram_re    (bram_re),
        .bram_raddr (bram_raddr),
        .vout       (vout),
        .busy       (busy),
        .warmed     (warmed),
        .done       (done),
        .err_cfg    (err_cfg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".we"},     32'(bram_we),    0);
        chk({tag, ".waddr"},  32'(bram_waddr), 0);
        chk({tag, ".re"},     32'(bram_re),    0);
        chk({tag, ".raddr"},  32'(bram_raddr), 0);
        chk({tag, ".vout"},   32'(vout),       0);
        chk({tag, ".busy"},   32'(busy),       0);
        chk({tag, ".warmed"}, 32'(warmed),     0);
        chk({tag, ".done"},   32'(done),       0);
        chk({tag, ".err"},    32'(err_cfg),    0);
    endtask

    // One clock cycle: drive inputs, compare outputs against the timeline
    // model, then advance the model across the coming rising edge.
    task automatic step(input bit st, input int cfg, input bit fl, input bit v);
        bit drain;
        int e_we, e_wa, e_re, e_ra, e_vout, e_busy, e_warm, e_done;
        @(negedge clk);
        start     = st;
        cfg_delay = cfg[ADDR_W:0];
        flush     = fl;
        vin       = v;
        #1;
        drain = 0;
        e_we = 0; e_wa = 0; e_re = 0; e_ra = 0;
        e_vout = 0; e_busy = 0; e_warm = 0; e_done = 0;
        if (m_busy) begin
            drain  = (m_f >= 0) && (m_k > m_f);
            e_busy = 1;
            e_re   = 1;
            e_we   = (v && !drain) ? 1 : 0;
            e_wa   = m_k % m_d;
            e_ra   = (m_k + 1) % m_d;
            e_warm = (!drain && m_k >= m_d) ? 1 : 0;
            e_vout = (m_k >= m_d && hist[(m_k - m_d) % 64]) ? 1 : 0;
            e_done = (m_f >= 0 && m_k == m_f + m_d) ? 1 : 0;
        end
        chk("bram_we",    32'(bram_we),    e_we);
        chk("bram_waddr", 32'(bram_waddr), e_wa);
        chk("bram_re",    32'(bram_re),    e_re);
        chk("bram_raddr", 32'(bram_raddr), e_ra);
        chk("vout",       32'(vout),       e_vout);
        chk("busy",       32'(busy),       e_busy);
        chk("warmed",     32'(warmed),     e_warm);
        chk("done",       32'(done),       e_done);
        chk("err_cfg",    32'(err_cfg),    32'(m_err));

        if (m_busy) begin
            hist[m_k % 64] = v && !drain;
            if (m_f < 0 && fl) m_f = m_k;
            if (m_f >= 0 && m_k == m_f + m_d) m_busy = 0;
            else m_k++;
        end else if (st) begin
            if (cfg >= 2 && cfg <= DEPTH) begin
                m_busy = 1;
                m_k    = 0;
                m_f    = -1;
                m_d    = cfg;
                m_err  = 0;
            end else begin
                m_err = 1;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        m_busy = 0;
        m_err  = 0;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        vin   = 1'b0;
        rstn  = 1'b1;
    endtask

    initial begin
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;

        // D=6, continuous vin for 20 cycles, then idle input, flush
        step(1, 6, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0);

        // D=6, sparse vin at t0, t0+3, t0+11
        step(1, 6, 0, 0);
        for (int i = 0; i < 25; i++) step(0, 0, 0, (i == 0 || i == 3 || i == 11));
        step(0, 0, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0);

        // flush in RUN with continuous vin; start/flush during DRAIN ignored
        step(1, 6, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        for (int i = 0; i < 8; i++) step((i == 2), 3, (i == 3), 1);

        // D=16 fully valid, then D=3 with no input: no stale valids
        step(1, 16, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        for (int i = 0; i < 18; i++) step(0, 0, 0, 0);
        step(1, 3, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);

        // illegal delays, flush in IDLE, start+flush together, flush in FILL
        step(1, 1, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(1, 17, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 1, 0);
        step(1, 4, 1, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
        step(1, 2, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

        // reset mid-RUN, then a fresh D=5 run
        step(1, 7, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
        pulse_reset();
        step(1, 5, 0, 0);
        for (int i = 0; i < 15; i++) step(0, 0, 0, (i % 3 != 1));
        step(0, 0, 1, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 700; i++) begin
            step(($urandom_range(0, 15) == 0),
                 int'($urandom_range(0, 18)),
                 ($urandom_range(0, 23) == 0),
                 $urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
